morph_frame_ctrl: RTL and testbench
===================================

# morph_frame_ctrl

Frame-synchronous controller for the binary morphology chain that follows Sobel edge thresholding. It holds a software-written mode, applies it only at an input frame boundary, and drives enable/select controls of two cascaded 3x3 binary morphology stages (A then B, each erosion or dilation, or bypass). It also monitors the processed bit stream and reports per-frame statistics: one-pixel count, line count check, and frame counter.

## Interface
Parameters:
- IMG_H, 480, expected active lines per frame.
- CNT_W, 20, width of the one-pixel counter.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_wr  in  1  single-cycle write strobe for cfg_mode.
- cfg_mode  in  3  0 bypass, 1 erode, 2 dilate, 3 open (erode→dilate), 4 close (dilate→erode), 5–7 reserved.
- cfg_ack  out  1  1-cycle pulse when a pending mode becomes active.
- cfg_err  out  1  sticky; set by a reserved mode write, cleared by reset only.
- in_vsync, in_href, in_clken  in  1 each  timing of the stream entering stage A.
- post_vsync, post_href, post_clken, post_bit  in  1 each  stream leaving stage B.
- stage_a_en, stage_b_en  out  1 each  1 = stage active, 0 = stage bypassed.
- stage_a_dil, stage_b_dil  out  1 each  1 = dilation, 0 = erosion.
- active_mode  out  3  currently applied mode.
- stat_ones  out  CNT_W  one-pixel count of last complete post frame.
- stat_line_err  out  1  last complete post frame line count ≠ IMG_H.
- stat_valid  out  1  1-cycle pulse when stat_* are updated.
- frame_cnt  out  16  complete post frames counted, wraps 0xFFFF→0.

## Operation
- Pending register: cfg_wr with a mode of 0–4 loads pend_mode and sets pend_v; last write wins. A reserved mode sets cfg_err and leaves pend_mode/pend_v unchanged.
- Input SOF = in_vsync high while its registered copy is low. At SOF, when pend_v=1 and post_vsync=0: active_mode←pend_mode, pend_v←0, cfg_ack pulses. When post_vsync=1 at SOF (previous output frame still draining), apply is deferred to the next SOF; pend_v stays 1.
- A cfg_wr in the SOF cycle is not applied at that SOF; it becomes pending for the next one.
- Control decode, registered from active_mode: bypass → a_en=0, b_en=0. Erode → a_en=1, a_dil=0, b_en=0. Dilate → a_en=1, a_dil=1, b_en=0. Open → a_en=1, a_dil=0, b_en=1, b_dil=1. Close → a_en=1, a_dil=1, b_en=1, b_dil=0. Dil bits of disabled stages are 0.
- Monitor FSM on the post stream:
  - MON_IDLE: entered at reset. Goes to MON_FRAME on post_vsync rising edge. If post_vsync is already high out of reset, wait for it to fall first.
  - MON_FRAME: clear counters on entry. ones += post_bit when post_clken & post_href; saturate at 2^CNT_W−1. lines += 1 on each post_href falling edge.
  - MON_FRAME → MON_DONE on post_vsync falling edge.
  - MON_DONE, 1 cycle: stat_ones←ones, stat_line_err←(lines≠IMG_H), frame_cnt+1, stat_valid=1. Then return to MON_IDLE.
- A post frame whose rising edge was not observed (reset mid-frame) never produces stat_valid.

## Timing
- Reset values of all outputs: 0; active_mode=0 (bypass); pend_v=0.
- cfg_ack, active_mode and the stage controls all update on the clock edge that samples the SOF condition, so they are valid from the cycle after in_vsync is first seen high.
- stat_valid asserts 2 cycles after post_vsync is first sampled low:
  - +1 cycle for edge detection into MON_DONE.
  - +1 cycle for the registered outputs.
- stat_* hold their values between pulses.
- Stage controls never change while in_vsync=1 or post_vsync=1.
- No combinational path from any input to any output.

## Test plan
- Reset, write mode 3 in the gap, then input frame → cfg_ack 1 cycle after SOF; a_en=1, a_dil=0, b_en=1, b_dil=1; active_mode=3.
- Write 1 then 2 in the same gap → only mode 2 is applied; one cfg_ack.
- Write 6 → cfg_err=1 and stays set; active_mode unchanged; no cfg_ack.
- SOF while post_vsync=1 with pend_v=1 → no apply; applied at the next SOF with post_vsync=0.
- Post frame of 480 lines with 1000 qualified ones → stat_ones=1000, stat_line_err=0, frame_cnt=1. Same with 479 lines → stat_line_err=1.
- Deassert rst_n mid post frame → all outputs 0 immediately; the partial frame yields no stat_valid; the next full frame reports correctly with frame_cnt=1.

Source files
------------

// File: rtl/morph_frame_ctrl.sv
// Frame-synchronous mode control for the two-stage binary morphology chain,
// plus per-frame one-pixel / line-count statistics on the processed stream.
module morph_frame_ctrl #(
    parameter int unsigned IMG_H = 480,
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_mode,
    output logic             cfg_ack,
    output logic             cfg_err,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic             in_clken,
    input  logic             post_vsync,
    input  logic             post_href,
    input  logic             post_clken,
    input  logic             post_bit,
    output logic             stage_a_en,
    output logic             stage_b_en,
    output logic             stage_a_dil,
    output logic             stage_b_dil,
    output logic [2:0]       active_mode,
    output logic [CNT_W-1:0] stat_ones,
    output logic             stat_line_err,
    output logic             stat_valid,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [1:0] {MonIdle, MonFrame, MonDone} mon_state_e;

    // {a_en, a_dil, b_en, b_dil}; dil bits of a disabled stage stay 0
    function automatic logic [3:0] decode_mode(input logic [2:0] mode);
        case (mode)
            3'd1:    decode_mode = 4'b1000;
            3'd2:    decode_mode = 4'b1100;
            3'd3:    decode_mode = 4'b1011;
            3'd4:    decode_mode = 4'b1110;
            default: decode_mode = 4'b0000;
        endcase
    endfunction

    logic             in_vsync_q;
    logic             post_vsync_q;
    logic             post_href_q;
    logic [2:0]       pend_mode;
    logic             pend_v;
    logic             sof;
    logic             apply;
    logic             mode_ok;
    mon_state_e       mon_state;
    logic [CNT_W-1:0] ones;
    logic [15:0]      lines;

    // The input-side line timing is not needed for frame-level control.
    logic unused_in_timing;
    assign unused_in_timing = ^{in_href, in_clken};

    assign sof     = in_vsync & ~in_vsync_q;
    assign apply   = sof & pend_v & ~post_vsync;
    assign mode_ok = (cfg_mode <= 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vsync_q  <= 1'b0;
            pend_mode   <= 3'd0;
            pend_v      <= 1'b0;
            cfg_ack     <= 1'b0;
            cfg_err     <= 1'b0;
            active_mode <= 3'd0;
            stage_a_en  <= 1'b0;
            stage_a_dil <= 1'b0;
            stage_b_en  <= 1'b0;
            stage_b_dil <= 1'b0;
        end else begin
            in_vsync_q <= in_vsync;
            cfg_ack    <= apply;
            if (apply) begin
                active_mode <= pend_mode;
                {stage_a_en, stage_a_dil, stage_b_en, stage_b_dil} <= decode_mode(pend_mode);
                pend_v <= 1'b0;
            end
            // A write in the SOF cycle lands after the apply, so it waits for the next SOF.
            if (cfg_wr) begin
                if (mode_ok) begin
                    pend_mode <= cfg_mode;
                    pend_v    <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_state     <= MonIdle;
            // Preset high so a frame already in flight at reset is not seen as a rising edge.
            post_vsync_q  <= 1'b1;
            post_href_q   <= 1'b0;
            ones          <= '0;
            lines         <= 16'd0;
            stat_ones     <= '0;
            stat_line_err <= 1'b0;
            stat_valid    <= 1'b0;
            frame_cnt     <= 16'd0;
        end else begin
            post_vsync_q <= post_vsync;
            post_href_q  <= post_href;
            stat_valid   <= 1'b0;
            case (mon_state)
                MonIdle: begin
                    if (post_vsync && !post_vsync_q) begin
                        ones      <= '0;
                        lines     <= 16'd0;
                        mon_state <= MonFrame;
                    end
                end
                MonFrame: begin
                    if (post_clken && post_href && post_bit && (ones != '1)) begin
                        ones <= ones + CNT_W'(1);
                    end
                    if (post_href_q && !post_href) begin
                        lines <= lines + 16'd1;
                    end
                    if (!post_vsync && post_vsync_q) begin
                        mon_state <= MonDone;
                    end
                end
                MonDone: begin
                    stat_ones     <= ones;
                    stat_line_err <= (lines != 16'(IMG_H));
                    frame_cnt     <= frame_cnt + 16'd1;
                    stat_valid    <= 1'b1;
                    mon_state     <= MonIdle;
                end
                default: mon_state <= MonIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Self-checking bench for morph_frame_ctrl: directed scenarios plus randomized
// config/frame sequences checked against a frame-level reference model.
module tb_morph_frame_ctrl;

    localparam int unsigned IMG_H = 480;
    localparam int unsigned CNT_W = 10;
    localparam int SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_wr;
    logic [2:0]       cfg_mode;
    logic             cfg_ack;
    logic             cfg_err;
    logic             in_vsync, in_href, in_clken;
    logic             post_vsync, post_href, post_clken, post_bit;
    logic             stage_a_en, stage_b_en, stage_a_dil, stage_b_dil;
    logic [2:0]       active_mode;
    logic [CNT_W-1:0] stat_ones;
    logic             stat_line_err;
    logic             stat_valid;
    logic [15:0]      frame_cnt;

    int cmp = 0;
    int errs = 0;

    // Reference model state
    logic       exp_pend_v;
    logic [2:0] exp_pend;
    logic [2:0] exp_active;
    logic       exp_err;
    logic       exp_ack;
    int         exp_frames;
    logic [3:0] ctrl_tbl [0:4];

    morph_frame_ctrl #(.IMG_H(IMG_H), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_wr        (cfg_wr),
        .cfg_mode      (cfg_mode),
        .cfg_ack       (cfg_ack),
        .cfg_err       (cfg_err),
        .in_vsync      (in_vsync),
        .in_href       (in_href),
        .in_clken      (in_clken),
        .post_vsync    (post_vsync),
        .post_href     (post_href),
        .post_clken    (post_clken),
        .post_bit      (post_bit),
        .stage_a_en    (stage_a_en),
        .stage_b_en    (stage_b_en),
        .stage_a_dil   (stage_a_dil),
        .stage_b_dil   (stage_b_dil),
        .active_mode   (active_mode),
        .stat_ones     (stat_ones),
        .stat_line_err (stat_line_err),
        .stat_valid    (stat_valid),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        exp_pend_v = 1'b0; exp_pend = 3'd0; exp_active = 3'd0;
        exp_err = 1'b0; exp_ack = 1'b0; exp_frames = 0;
    endtask

    task automatic model_write(input logic [2:0] m);
        if (m <= 3'd4) begin exp_pend = m; exp_pend_v = 1'b1; end
        else exp_err = 1'b1;
    endtask

    task automatic model_sof(input logic post_busy);
        exp_ack = exp_pend_v && !post_busy;
        if (exp_ack) begin exp_active = exp_pend; exp_pend_v = 1'b0; end
    endtask

    // ---------------- stimulus ----------------
    task automatic cfg_write(input logic [2:0] m);
        @(negedge clk); cfg_wr = 1'b1; cfg_mode = m;
        @(negedge clk); cfg_wr = 1'b0;
        model_write(m);
    endtask

    // Raises in_vsync; returns at the negedge after the SOF edge.
    task automatic pulse_sof();
        @(negedge clk); in_vsync = 1'b1;
        @(negedge clk);
    endtask

    // want < 0: random clken/bits; otherwise the first `want` qualified pixels are ones.
    task automatic post_frame(input int nlines, input int ppl, input int want, output int ones);
        ones = 0;
        @(negedge clk); post_vsync = 1'b1;
        repeat (2) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < ppl; p++) begin
                @(negedge clk);
                post_href  = 1'b1;
                post_clken = (want >= 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                post_bit   = (want >= 0) ? 1'(ones < want) : 1'($urandom_range(0, 1));
                if (post_clken && post_bit) ones++;
            end
            // Blanking with clken/bit high must not be counted.
            @(negedge clk); post_href = 1'b0; post_clken = 1'b1; post_bit = 1'b1;
            @(negedge clk); post_clken = 1'b0; post_bit = 1'b0;
        end
        @(negedge clk); post_vsync = 1'b0;
        if (ones > SAT) ones = SAT;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_mode = 3'd0;
        in_vsync = 1'b0; in_href = 1'b0; in_clken = 1'b0;
        post_vsync = 1'b0; post_href = 1'b0; post_clken = 1'b0; post_bit = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        cmp++;
        if ({cfg_ack, cfg_err, stage_a_en, stage_a_dil, stage_b_en, stage_b_dil, active_mode,
             stat_ones, stat_line_err, stat_valid, frame_cnt} !== '0) begin
            errs++; $display("FAIL reset_outputs: outputs not all zero (mode=%0d cnt=%0d)",
                             active_mode, frame_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_apply_open();
        cfg_write(3'd3);
        pulse_sof(); model_sof(1'b0);
        cmp++;
        if (cfg_ack !== 1'b1) begin
            errs++; $display("FAIL open_ack: got %0b expected 1", cfg_ack);
        end
        cmp++;
        if ({active_mode, stage_a_en, stage_a_dil, stage_b_en, stage_b_dil} !== {3'd3, 4'b1011})
        begin
            errs++; $display("FAIL open_ctrl: got mode %0d ctrl %4b expected 3 1011",
                             active_mode, {stage_a_en, stage_a_dil, stage_b_en, stage_b_dil});
        end
        @(negedge clk); in_vsync = 1'b0;
        cmp++;
        if (cfg_ack !== 1'b0) begin
            errs++; $display("FAIL open_ack_pulse: got %0b expected 0", cfg_ack);
        end
    endtask

    task automatic test_last_write_wins();
        int acks = 0;
        cfg_write(3'd1);
        cfg_write(3'd2);
        pulse_sof(); model_sof(1'b0);
        for (int i = 0; i < 4; i++) begin
            acks += int'(cfg_ack);
            @(negedge clk); in_vsync = 1'b0;
        end
        pulse_sof();
        acks += int'(cfg_ack);
        @(negedge clk); in_vsync = 1'b0;
        cmp++;
        if (acks != 1) begin
            errs++; $display("FAIL lww_ack_count: got %0d expected 1", acks);
        end
        cmp++;
        if ({active_mode, stage_a_en, stage_a_dil, stage_b_en, stage_b_dil} !==
            {exp_active, ctrl_tbl[exp_active]}) begin
            errs++; $display("FAIL lww_mode: got %0d expected %0d", active_mode, exp_active);
        end
    endtask

    task automatic test_reserved();
        cfg_write(3'd6);
        cmp++;
        if (cfg_err !== 1'b1) begin
            errs++; $display("FAIL reserved_err: got %0b expected 1", cfg_err);
        end
        pulse_sof(); model_sof(1'b0);
        cmp++;
        if (cfg_ack !== 1'b0 || active_mode !== exp_active) begin
            errs++; $display("FAIL reserved_noapply: got ack %0b mode %0d expected 0 %0d",
                             cfg_ack, active_mode, exp_active);
        end
        repeat (3) @(negedge clk);
        in_vsync = 1'b0;
        cmp++;
        if (cfg_err !== 1'b1) begin
            errs++; $display("FAIL reserved_sticky: got %0b expected 1", cfg_err);
        end
    endtask

    task automatic test_deferred();
        cfg_write(3'd4);
        @(negedge clk); post_vsync = 1'b1;
        pulse_sof(); model_sof(1'b1);
        cmp++;
        if (cfg_ack !== 1'b0 || active_mode !== 3'd2) begin
            errs++; $display("FAIL defer_hold: got ack %0b mode %0d expected 0 2",
                             cfg_ack, active_mode);
        end
        @(negedge clk); in_vsync = 1'b0; post_vsync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_frames++;
        cmp++;
        if ({stat_valid, stat_ones, stat_line_err, frame_cnt} !==
            {1'b1, CNT_W'(0), 1'b1, 16'(exp_frames)}) begin
            errs++; $display("FAIL defer_empty_stats: got v%0b ones %0d err %0b cnt %0d",
                             stat_valid, stat_ones, stat_line_err, frame_cnt);
        end
        pulse_sof(); model_sof(1'b0);
        cmp++;
        if ({cfg_ack, active_mode, stage_a_en, stage_a_dil, stage_b_en, stage_b_dil} !==
            {1'b1, 3'd4, 4'b1110}) begin
            errs++; $display("FAIL defer_apply: got ack %0b mode %0d expected 1 4",
                             cfg_ack, active_mode);
        end
        @(negedge clk); in_vsync = 1'b0;
    endtask

    task automatic test_sof_write();
        cfg_write(3'd1);
        @(negedge clk); in_vsync = 1'b1; cfg_wr = 1'b1; cfg_mode = 3'd0;
        model_sof(1'b0); model_write(3'd0);
        @(negedge clk); cfg_wr = 1'b0;
        cmp++;
        if (cfg_ack !== 1'b1 || active_mode !== 3'd1) begin
            errs++; $display("FAIL sofwr_first: got ack %0b mode %0d expected 1 1",
                             cfg_ack, active_mode);
        end
        @(negedge clk); in_vsync = 1'b0;
        pulse_sof(); model_sof(1'b0);
        cmp++;
        if (cfg_ack !== 1'b1 || active_mode !== 3'd0 || stage_a_en !== 1'b0) begin
            errs++; $display("FAIL sofwr_next: got ack %0b mode %0d expected 1 0",
                             cfg_ack, active_mode);
        end
        @(negedge clk); in_vsync = 1'b0;
    endtask

    task automatic test_stats();
        int nl [3] = '{480, 479, 480};
        int want [3] = '{1000, 1000, 4000};
        int ones;
        for (int k = 0; k < 3; k++) begin
            post_frame(nl[k], 4, want[k], ones);
            @(negedge clk);
            cmp++;
            if (stat_valid !== 1'b0) begin
                errs++; $display("FAIL stats_early_%0d: got %0b expected 0", k, stat_valid);
            end
            @(negedge clk);
            exp_frames++;
            cmp++;
            if ({stat_valid, stat_ones, stat_line_err, frame_cnt} !==
                {1'b1, CNT_W'(ones), 1'(nl[k] != IMG_H), 16'(exp_frames)}) begin
                errs++; $display("FAIL stats_%0d: got v%0b ones %0d err %0b cnt %0d expected %0d",
                                 k, stat_valid, stat_ones, stat_line_err, frame_cnt, ones);
            end
            @(negedge clk);
            cmp++;
            if (stat_valid !== 1'b0 || stat_ones !== CNT_W'(ones)) begin
                errs++; $display("FAIL stats_hold_%0d: got v%0b ones %0d", k, stat_valid,
                                 stat_ones);
            end
        end
    endtask

    task automatic test_random();
        int ones, nl, sel;
        logic defer;
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(0, 3)) cfg_write(3'($urandom_range(0, 7)));
            cmp++;
            if (cfg_err !== exp_err) begin
                errs++; $display("FAIL rnd_err_%0d: got %0b expected %0b", it, cfg_err, exp_err);
            end
            defer = 1'($urandom_range(0, 3) == 0);
            if (defer) begin @(negedge clk); post_vsync = 1'b1; end
            pulse_sof(); model_sof(defer);
            cmp++;
            if ({cfg_ack, active_mode, stage_a_en, stage_a_dil, stage_b_en, stage_b_dil} !==
                {exp_ack, exp_active, ctrl_tbl[exp_active]}) begin
                errs++; $display("FAIL rnd_sof_%0d: got ack %0b mode %0d expected %0b %0d",
                                 it, cfg_ack, active_mode, exp_ack, exp_active);
            end
            @(negedge clk); in_vsync = 1'b0;
            if (defer) begin
                post_vsync = 1'b0;
                ones = 0; nl = 0;
            end else begin
                sel = $urandom_range(0, 3);
                nl = (sel == 0) ? 480 : (sel == 1) ? 479 : (sel == 2) ? 481
                                                          : $urandom_range(1, 20);
                post_frame(nl, $urandom_range(1, 3), -1, ones);
            end
            @(negedge clk);
            @(negedge clk);
            exp_frames++;
            cmp++;
            if ({stat_valid, stat_ones, stat_line_err, frame_cnt} !==
                {1'b1, CNT_W'(ones), 1'(nl != IMG_H), 16'(exp_frames)}) begin
                errs++; $display("FAIL rnd_stats_%0d: got v%0b ones %0d err %0b cnt %0d exp %0d %0d",
                                 it, stat_valid, stat_ones, stat_line_err, frame_cnt, ones, nl);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int ones;
        int seen = 0;
        @(negedge clk); post_vsync = 1'b1;
        repeat (3) begin
            @(negedge clk); post_href = 1'b1; post_clken = 1'b1; post_bit = 1'b1;
            @(negedge clk); post_href = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp++;
        if ({cfg_ack, cfg_err, stage_a_en, stage_a_dil, stage_b_en, stage_b_dil, active_mode,
             stat_ones, stat_line_err, stat_valid, frame_cnt} !== '0) begin
            errs++; $display("FAIL midrst_outputs: not zero (mode=%0d cnt=%0d ones=%0d)",
                             active_mode, frame_cnt, stat_ones);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); post_href = 1'b1;
            @(negedge clk); post_href = 1'b0;
        end
        @(negedge clk); post_vsync = 1'b0; post_bit = 1'b0; post_clken = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen += int'(stat_valid);
        end
        cmp++;
        if (seen != 0) begin
            errs++; $display("FAIL midrst_partial: got %0d stat_valid pulses expected 0", seen);
        end
        post_frame(480, 2, -1, ones);
        @(negedge clk);
        @(negedge clk);
        exp_frames++;
        cmp++;
        if ({stat_valid, stat_ones, stat_line_err, frame_cnt} !==
            {1'b1, CNT_W'(ones), 1'b0, 16'(exp_frames)}) begin
            errs++; $display("FAIL midrst_next: got v%0b ones %0d err %0b cnt %0d expected %0d",
                             stat_valid, stat_ones, stat_line_err, frame_cnt, ones);
        end
    endtask

    initial begin
        ctrl_tbl[0] = 4'b0000;
        ctrl_tbl[1] = 4'b1000;
        ctrl_tbl[2] = 4'b1100;
        ctrl_tbl[3] = 4'b1011;
        ctrl_tbl[4] = 4'b1110;
        test_reset();
        test_apply_open();
        test_last_write_wins();
        test_reserved();
        test_deferred();
        test_sof_write();
        test_stats();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
